// File: rtl/player_state_ctrl.sv
// Top-level control FSM for the SD-card WAV player: debounced key input,
// SD init / file search / playback sequencing and the 4-bit state code.
module player_state_ctrl #(
    parameter int DEB_CNT   = 1_000_000,
    parameter int SEARCH_TO = 250_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       sd_init_done,
    input  logic       search_found,
    input  logic       search_fail,
    input  logic       play_done,
    output logic       search_start,
    output logic       play_en,
    output logic [3:0] state_code
);

    localparam int DW = $clog2(DEB_CNT + 1);
    localparam int TW = $clog2(SEARCH_TO + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(SEARCH_TO - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT,
        S_SEARCH,
        S_PLAY,
        S_ERR
    } state_t;

    logic          r_sync1, r_sync2;
    logic          r_key_stable, r_key_stable_d;
    logic          r_key_press;
    logic [DW-1:0] r_deb_cnt;
    logic [TW-1:0] r_to_cnt;
    state_t        r_state, w_state_nxt;
    logic [3:0]    r_code, w_code_nxt;
    logic          r_play_en, r_search_start;

    // Key path: 2-flop synchroniser, then a level only accepted after DEB_CNT
    // consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_key_stable   <= 1'b1;
            r_key_stable_d <= 1'b1;
            r_key_press    <= 1'b0;
            r_deb_cnt      <= '0;
        end else begin
            r_sync1        <= key_n;
            r_sync2        <= r_sync1;
            r_key_stable_d <= r_key_stable;
            r_key_press    <= r_key_stable_d & ~r_key_stable;
            if (r_sync2 == r_key_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_MAX) begin
                r_key_stable <= r_sync2;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
        end
    end

    // Card loss beats every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = 4'd0;
        if (r_state != S_INIT && !sd_init_done) begin
            w_state_nxt = S_INIT;
        end else begin
            case (r_state)
                S_INIT:   if (sd_init_done) w_state_nxt = S_WAIT;
                S_WAIT:   if (r_key_press) w_state_nxt = S_SEARCH;
                S_SEARCH: begin
                    if (search_found)            w_state_nxt = S_PLAY;
                    else if (search_fail)        w_state_nxt = S_ERR;
                    else if (r_to_cnt == TO_MAX) w_state_nxt = S_ERR;
                end
                S_PLAY:   if (play_done || r_key_press) w_state_nxt = S_WAIT;
                S_ERR:    if (r_key_press) w_state_nxt = S_SEARCH;
                default:  w_state_nxt = S_INIT;
            endcase
        end
        case (w_state_nxt)
            S_WAIT:   w_code_nxt = 4'd1;
            S_SEARCH: w_code_nxt = 4'd2;
            S_PLAY:   w_code_nxt = 4'd3;
            S_ERR:    w_code_nxt = 4'd15;
            default:  w_code_nxt = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_INIT;
            r_code         <= 4'd0;
            r_play_en      <= 1'b0;
            r_search_start <= 1'b0;
            r_to_cnt       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_code         <= w_code_nxt;
            r_play_en      <= (w_state_nxt == S_PLAY);
            r_search_start <= (w_state_nxt == S_SEARCH) && (r_state != S_SEARCH);
            // Counter is zero on SEARCH entry and counts cycles spent there.
            r_to_cnt       <= (w_state_nxt == S_SEARCH && r_state == S_SEARCH) ?
                              r_to_cnt + TW'(1) : '0;
        end
    end

    assign search_start = r_search_start;
    assign play_en      = r_play_en;
    assign state_code   = r_code;

endmodule

// File: tb/tb_player_state_ctrl.sv
// Bench for player_state_ctrl: reset/table vectors, directed key/search/play
// corner sequences, then random stimulus against a behavioural model.
module tb_player_state_ctrl;
    localparam int D  = 8;
    localparam int TO = 100;
    localparam int NR = 3000;

    logic       clk = 1'b0, rst_n = 1'b0, key_n = 1'b1;
    logic       sd = 1'b0, sf = 1'b0, sfl = 1'b0, pd = 1'b0;
    logic       ss, pe;
    logic [3:0] code;
    int         checks = 0, errors = 0;

    always #10 clk = ~clk;

    player_state_ctrl #(.DEB_CNT(D), .SEARCH_TO(TO)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .sd_init_done(sd),
        .search_found(sf), .search_fail(sfl), .play_done(pd),
        .search_start(ss), .play_en(pe), .state_code(code)
    );

    typedef struct {
        logic sd, sf, sfl, pd;
        int   code;
        logic pe, ss;
    } vec_t;
    vec_t tbl[10];

    // Reference model state: state codes, key sample history, fall events.
    bit keyh[0:4095];
    bit fallh[0:4095];
    int m_cyc, m_code, m_enter;
    bit m_stable, m_pe, m_ss;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; key_n = 1'b1; sd = 1'b0; sf = 1'b0; sfl = 1'b0; pd = 1'b0;
        step; step;
        rst_n = 1'b1;
    endtask

    // Holds the key low until SEARCH is observed (bounded); leaves key low.
    task automatic press_key(output int lat, output int ss_seen, output int ss_cnt);
        lat = -1; ss_seen = 0; ss_cnt = 0;
        key_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step;
            ss_cnt += int'(ss);
            if (code == 4'd2) begin
                lat = i; ss_seen = int'(ss);
                break;
            end
        end
    endtask

    function automatic bit ksamp(input int i);
        return (i < 1) ? 1'b1 : keyh[i];
    endfunction

    // Stable key flips once the last D synchronised samples all disagree with
    // it; a press is seen by the FSM two edges after a 1->0 flip.
    task automatic model_step(input bit k, input bit sdv, input bit sfv,
                              input bit sflv, input bit pdv);
        int n, nxt;
        bit press, alldiff;
        n = m_cyc;
        keyh[n] = k;
        press = (n - 2 >= 1) ? fallh[n-2] : 1'b0;
        alldiff = 1'b1;
        for (int i = n - 1 - D; i <= n - 2; i++)
            if (ksamp(i) == m_stable) alldiff = 1'b0;
        fallh[n] = 1'b0;
        if (alldiff) begin
            m_stable = !m_stable;
            fallh[n] = !m_stable;
        end
        nxt = m_code;
        if (m_code != 0 && !sdv) nxt = 0;
        else begin
            case (m_code)
                0:  if (sdv) nxt = 1;
                1:  if (press) nxt = 2;
                2:  if (sfv) nxt = 3;
                    else if (sflv) nxt = 15;
                    else if (n - m_enter >= TO) nxt = 15;
                3:  if (pdv || press) nxt = 1;
                15: if (press) nxt = 2;
                default: nxt = 0;
            endcase
        end
        m_ss = (nxt == 2 && m_code != 2);
        if (m_ss) m_enter = n;
        m_code = nxt;
        m_pe = (nxt == 3);
        m_cyc++;
    endtask

    initial begin
        int lat, ssn, ssc, bad, k, run, sdl;
        bit cur;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};

        // Reset state, then 20 cycles with no card, then card ready.
        @(negedge clk);
        chk("rst_code", int'(code), 0);
        chk("rst_pe", int'(pe), 0);
        chk("rst_ss", int'(ss), 0);
        do_reset;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (code != 4'd0 || pe || ss) bad++;
        end
        chk("init_hold", bad, 0);
        sd = 1'b1;
        step;
        chk("init_to_wait", int'(code), 1);

        // Table vectors: one edge each, dropped pulses and card loss.
        do_reset;
        foreach (tbl[i]) begin
            sd = tbl[i].sd; sf = tbl[i].sf; sfl = tbl[i].sfl; pd = tbl[i].pd;
            step;
            chk($sformatf("vec%0d_code", i), int'(code), tbl[i].code);
            chk($sformatf("vec%0d_pe", i), int'(pe), int'(tbl[i].pe));
            chk($sformatf("vec%0d_ss", i), int'(ss), int'(tbl[i].ss));
        end
        sf = 1'b0; sfl = 1'b0; pd = 1'b0; sd = 1'b1;

        // Bouncy key: short lows must be ignored.
        ssc = 0; bad = 0;
        for (int b = 0; b < 3; b++) begin
            key_n = 1'b0;
            for (int i = 0; i < 5; i++) begin step; ssc += int'(ss); if (code != 4'd1) bad++; end
            key_n = 1'b1;
            for (int i = 0; i < 2; i++) begin step; ssc += int'(ss); if (code != 4'd1) bad++; end
        end
        chk("bounce_ss", ssc, 0);
        chk("bounce_state", bad, 0);
        press_key(lat, ssn, ssc);
        chk("press_lat_ok", int'(lat >= 10 && lat <= 12), 1);
        chk("press_ss", ssn, 1);
        chk("press_ss_cnt", ssc, 1);
        ssc = 0;
        for (int i = lat; i < 20; i++) begin step; ssc += int'(ss); end
        key_n = 1'b1;
        for (int i = 0; i < 20; i++) begin step; ssc += int'(ss); end
        chk("release_ss", ssc, 0);
        chk("release_state", int'(code), 2);

        // found and fail together: found wins; then play_done.
        sf = 1'b1; sfl = 1'b1;
        step;
        sf = 1'b0; sfl = 1'b0;
        chk("found_wins_code", int'(code), 3);
        chk("found_wins_pe", int'(pe), 1);
        step; step; step;
        chk("play_pe_hold", int'(pe), 1);
        pd = 1'b1;
        step;
        pd = 1'b0;
        chk("play_done_code", int'(code), 1);
        chk("play_done_pe", int'(pe), 0);

        // Search timeout, then retry from ERROR.
        press_key(lat, ssn, ssc);
        key_n = 1'b1;
        chk("t4_enter", int'(code), 2);
        k = 0;
        while (code == 4'd2 && k < 120) begin step; k++; end
        chk("timeout_cycles", k, TO);
        chk("timeout_code", int'(code), 15);
        press_key(lat, ssn, ssc);
        key_n = 1'b1;
        chk("retry_code", int'(code), 2);
        chk("retry_ss", ssn, 1);

        // Card loss in PLAY.
        sf = 1'b1;
        step;
        sf = 1'b0;
        chk("t5_play", int'(code), 3);
        sd = 1'b0;
        step;
        chk("cardloss_code", int'(code), 0);
        chk("cardloss_pe", int'(pe), 0);
        pd = 1'b1;
        step;
        pd = 1'b0;
        chk("cardloss_pd_drop", int'(code), 0);
        sd = 1'b1;
        step;
        chk("card_back", int'(code), 1);

        // Asynchronous reset between edges mid-PLAY.
        for (int i = 0; i < 12; i++) step;
        press_key(lat, ssn, ssc);
        key_n = 1'b1;
        sf = 1'b1;
        step;
        sf = 1'b0;
        chk("t6_play", int'(code), 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_code", int'(code), 0);
        chk("async_rst_pe", int'(pe), 0);
        chk("async_rst_ss", int'(ss), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus against the behavioural model.
        do_reset;
        m_cyc = 1; m_code = 0; m_enter = 0; m_stable = 1'b1; m_pe = 1'b0; m_ss = 1'b0;
        run = 0; sdl = 0; cur = 1'b1;
        for (int c = 0; c < NR; c++) begin
            if (run == 0) begin
                cur = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 20);
            end
            run--;
            key_n = cur;
            if (sdl == 0 && $urandom_range(0, 299) == 0) sdl = $urandom_range(1, 3);
            sd = (sdl == 0);
            if (sdl > 0) sdl--;
            sf  = ($urandom_range(0, 119) == 0);
            sfl = ($urandom_range(0, 199) == 0);
            pd  = ($urandom_range(0, 39) == 0);
            model_step(key_n, sd, sf, sfl, pd);
            step;
            chk("rand_code", int'(code), m_code);
            chk("rand_pe", int'(pe), int'(m_pe));
            chk("rand_ss", int'(ss), int'(m_ss));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/player_state_ctrl.md
Name: player_state_ctrl

Overview:
- Top-level control FSM for the SD-card WAV player. Sequences SD init, waits for a debounced key press, starts the WAV file search, and enables playback.
- Drives the 4-bit state_code consumed by the 7-segment state decoder.
- Error state uses code 15, which the decoder shows as blank.

Parameters:
DEB_CNT, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
SEARCH_TO, 250_000_000, max cycles allowed in SEARCH before declaring error (5 s at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_n  in  1  raw push button, active-low, asynchronous to clk, bouncy
sd_init_done  in  1  level; SD card initialised and present
search_found  in  1  one-cycle pulse; WAV file located
search_fail  in  1  one-cycle pulse; no WAV file on card
play_done  in  1  one-cycle pulse; end of file reached
search_start  out  1  one-cycle pulse; launch file search
play_en  out  1  level; audio streaming enabled
state_code  out  4  0=INIT, 1=WAIT_KEY, 2=SEARCH, 3=PLAY, 15=ERROR

Behaviour:
- Reset (rst_n low, any time, including mid-play):
  - state=INIT, state_code=0, play_en=0, search_start=0.
  - Sync flops=1, key_stable=1, key_press=0, debounce and timeout counters=0.
- Key path:
  - key_n passes through a 2-flop synchroniser.
  - The debounce counter increments each cycle the synced value differs from key_stable, and clears to 0 when they match.
  - When the counter reaches DEB_CNT-1 while still differing, key_stable takes the synced value and the counter clears.
  - key_press is a registered one-cycle pulse, high the cycle after key_stable goes 1->0. Release (0->1) produces no pulse.
  - Glitches shorter than DEB_CNT cycles are ignored.
  - Nominal latency from key_n falling to key_press high: DEB_CNT+3 cycles. Bench tolerance is ±1.
- FSM (all outputs registered; state_code and play_en change on the same edge as the state):
  - INIT: sd_init_done=1 -> WAIT_KEY.
  - WAIT_KEY: key_press -> SEARCH. search_start=1 on the first SEARCH cycle only.
  - SEARCH:
    - Timeout counter cleared on entry, increments each cycle.
    - search_found -> PLAY.
    - search_fail -> ERROR.
    - Counter reaching SEARCH_TO-1 -> ERROR.
    - search_found and search_fail in the same cycle -> PLAY (found wins).
    - key_press is ignored in SEARCH.
  - PLAY: play_en=1 for every cycle state_code=3.
    - play_done -> WAIT_KEY.
    - key_press -> WAIT_KEY (user stop).
    - Both in the same cycle -> WAIT_KEY (single transition).
  - ERROR: key_press -> SEARCH (retry, new search_start pulse).
  - Card loss: sd_init_done=0 in any state other than INIT -> INIT next cycle. play_en drops on that same edge. This has priority over every other transition.
- Pulse inputs arriving in states that do not consume them are dropped, with no latching. Example: play_done while in WAIT_KEY.
- search_start is never high in two consecutive cycles.
- state_code takes only the values 0, 1, 2, 3 and 15.

Test Plan:
Use DEB_CNT=8, SEARCH_TO=100, 50 MHz clock.
1. Reset release with sd_init_done=0 for 20 cycles, then 1 -> state_code 0 throughout, then 1 on the next edge. play_en=0, search_start=0 throughout.
2. In WAIT_KEY, drive key_n low with 5-cycle bounce pulses, then hold low for 20 cycles -> no pulse during bounce. After the hold: exactly one search_start pulse, state_code=2 about 11 cycles after the final fall. Releasing the key produces no second event.
3. In SEARCH, pulse search_found and search_fail on the same cycle -> state_code=3 and play_en=1 on the next edge. Then pulse play_done -> state_code=1, play_en=0.
4. In SEARCH, give no response -> state_code=15 exactly 100 cycles after entering SEARCH. A key press then gives state_code=2 and a fresh search_start pulse.
5. In PLAY, deassert sd_init_done -> state_code=0 and play_en=0 on the next edge. A play_done pulse afterwards has no effect.
6. Assert rst_n low asynchronously mid-PLAY, between clock edges -> play_en and state_code go to 0 immediately, without waiting for a clock edge.
